// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder and keep the difference when it does not go negative.
module div_iter_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] t_ext;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // The top bit of r is always zero, so the extended trial value and the
  // extended difference give the sign of D without a separate comparator.
  always_comb begin
    t_ext  = {r, q[WIDTH-1]};
    diff   = t_ext - {2'b00, divisor};
    fits   = ~diff[WIDTH+1];
    r_next = fits ? diff[WIDTH:0] : t_ext[WIDTH:0];
    q_next = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle DIV/DIVU unit: captures operands, iterates one quotient bit
// per cycle, applies sign fix-up and strobes done for one cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring iteration per cycle, WIDTH cycles
// FIX   | apply result signs, load quotient/remainder
// DONE  | one-cycle done strobe; may relaunch back-to-back
module div_seq_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] b_mag;
  logic             neg_q, neg_r;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             accept;
  logic             b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (b_mag),
    .r_next  (r_nxt),
    .q_next  (q_nxt)
  );

  // Operand conditioning; the magnitude of the most negative value wraps to
  // itself, which is the correct unsigned magnitude.
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    b_zero = (b == '0);
    a_neg  = is_signed & a[WIDTH-1];
    b_neg  = is_signed & b[WIDTH-1];
    a_abs  = a_neg ? (~a + 1'b1) : a;
    b_abs  = b_neg ? (~b + 1'b1) : b;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a zero divisor skips straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = b_zero ? DONE : CALC;
      CALC:    if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (start) state_nxt = b_zero ? DONE : CALC;
               else       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      cnt         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      b_mag       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      busy <= (state_nxt == CALC) || (state_nxt == FIX);
      done <= (state_nxt == DONE);
      if (accept) begin
        cnt         <= '0;
        r_q         <= '0;
        q_q         <= a_abs;
        b_mag       <= b_abs;
        neg_q       <= a_neg ^ b_neg;
        neg_r       <= a_neg;
        div_by_zero <= b_zero;
        if (b_zero) begin
          quotient  <= DIV_BY_ZERO_Q;
          remainder <= a;
        end
      end else if (state == CALC) begin
        r_q <= r_nxt;
        q_q <= q_nxt;
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        quotient  <= neg_q ? (~q_q + 1'b1) : q_q;
        remainder <= neg_r ? (~r_q[WIDTH-1:0] + 1'b1) : r_q[WIDTH-1:0];
      end
    end
  end

endmodule
